// File: rtl/cpu_ctrl_sequencer_if.sv
// Fetch bus plus the ALU and accumulator connections between the CPU control sequencer and the datapath.
// master = sequencer side; slave = program memory / ALU / accumulator side.
interface cpu_ctrl_sequencer_if #(
  parameter int unsigned PC_WIDTH   = 8,
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  instr_req;
  logic [PC_WIDTH-1:0]   instr_addr;
  logic                  instr_valid;
  logic [7:0]            instr_data;
  logic [2:0]            alu_component_select;
  logic [DATA_WIDTH-1:0] alu_input_1;
  logic [DATA_WIDTH-1:0] alu_input_2;
  logic [DATA_WIDTH-1:0] alu_result;
  logic [DATA_WIDTH-1:0] acc_read_port;
  logic                  acc_write_bit;
  logic [DATA_WIDTH-1:0] acc_write_port;

  modport master (
    output instr_req, instr_addr, alu_component_select, alu_input_1, alu_input_2,
           acc_write_bit, acc_write_port,
    input  instr_valid, instr_data, alu_result, acc_read_port
  );

  modport slave (
    input  instr_req, instr_addr, alu_component_select, alu_input_1, alu_input_2,
           acc_write_bit, acc_write_port,
    output instr_valid, instr_data, alu_result, acc_read_port
  );
endinterface

// File: rtl/cpu_ctrl_sequencer.sv
// Control sequencer for the 8-bit CPU: fetches, decodes and executes byte instructions.
// Optional macro CTRL_BRANCH_EN turns op 111 with bit 4 clear into JMPZ (jump if acc == 0).
module cpu_ctrl_sequencer #(
  parameter int unsigned PC_WIDTH   = 8,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  cpu_ctrl_sequencer_if.master  bus,
  input  logic [DATA_WIDTH-1:0] in0,
  input  logic [DATA_WIDTH-1:0] in1,
  input  logic [DATA_WIDTH-1:0] in2,
  output logic [DATA_WIDTH-1:0] out0,
  output logic [DATA_WIDTH-1:0] out1,
  output logic [DATA_WIDTH-1:0] out2,
  output logic                  halted
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_FETCH_IMM, S_EXEC, S_WB, S_HALT
  } state_e;

  state_e                state_q, state_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic [4:0]            ir_q, ir_d;
  logic [7:0]            imm_q, imm_d;
  logic [2:0]            sel_q, sel_d;
  logic [DATA_WIDTH-1:0] a1_q, a1_d, a2_q, a2_d;
  logic [DATA_WIDTH-1:0] accw_q, accw_d;
  logic [DATA_WIDTH-1:0] out0_q, out0_d, out1_q, out1_d, out2_q, out2_d;

  logic [2:0]            op;
  logic [1:0]            src;
  logic                  is_alu;
  logic [DATA_WIDTH-1:0] operand;
  logic [2:0]            exec_sel;
  logic [DATA_WIDTH-1:0] exec_a1;

  assign op     = ir_q[4:2];
  assign src    = ir_q[1:0];
  assign is_alu = (op <= 3'b101);

  // Takes instr_data[7:3]: op in [4:2], src/dst in [1:0].
  function automatic logic needs_imm(input logic [4:0] b);
`ifdef CTRL_BRANCH_EN
    return ((b[4:2] <= 3'b101) && (b[1:0] == 2'b11)) || ((b[4:2] == 3'b111) && !b[1]);
`else
    return (b[4:2] <= 3'b101) && (b[1:0] == 2'b11);
`endif
  endfunction

  always_comb begin
    operand = imm_q;
    case (src)
      2'b00:   operand = in0;
      2'b01:   operand = in1;
      2'b10:   operand = in2;
      default: operand = imm_q;
    endcase
    exec_sel = op;
    exec_a1  = bus.acc_read_port;
    if (op == 3'b101) begin
      exec_sel = 3'b111;
      exec_a1  = operand;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    imm_d   = imm_q;
    sel_d   = sel_q;
    a1_d    = a1_q;
    a2_d    = a2_q;
    accw_d  = accw_q;
    out0_d  = out0_q;
    out1_d  = out1_q;
    out2_d  = out2_q;
    case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          pc_d    = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (bus.instr_valid) begin
          ir_d    = bus.instr_data[7:3];
          pc_d    = pc_q + PC_WIDTH'(1);
          state_d = needs_imm(bus.instr_data[7:3]) ? S_FETCH_IMM : S_EXEC;
        end
      end
      S_FETCH_IMM: begin
        if (bus.instr_valid) begin
          imm_d   = bus.instr_data;
          pc_d    = pc_q + PC_WIDTH'(1);
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_alu) begin
          sel_d   = exec_sel;
          a1_d    = exec_a1;
          a2_d    = operand;
          accw_d  = bus.alu_result;
          state_d = S_WB;
        end else if (op == 3'b110) begin
          case (src)
            2'b00:   out0_d = bus.acc_read_port;
            2'b01:   out1_d = bus.acc_read_port;
            2'b10:   out2_d = bus.acc_read_port;
            default: ;
          endcase
          state_d = S_FETCH;
        end else begin
`ifdef CTRL_BRANCH_EN
          if (!src[1]) begin
            if (bus.acc_read_port == '0) pc_d = PC_WIDTH'(imm_q);
            state_d = S_FETCH;
          end else begin
            state_d = S_HALT;
          end
`else
          state_d = S_HALT;
`endif
        end
      end
      S_WB:    state_d = S_FETCH;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      imm_q   <= '0;
      sel_q   <= '0;
      a1_q    <= '0;
      a2_q    <= '0;
      accw_q  <= '0;
      out0_q  <= '0;
      out1_q  <= '0;
      out2_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      imm_q   <= imm_d;
      sel_q   <= sel_d;
      a1_q    <= a1_d;
      a2_q    <= a2_d;
      accw_q  <= accw_d;
      out0_q  <= out0_d;
      out1_q  <= out1_d;
      out2_q  <= out2_d;
    end
  end

  // The _d values equal the live EXEC drive and the held _q values elsewhere,
  // so the ALU sees new operands during EXEC and keeps them afterwards.
  assign bus.alu_component_select = sel_d;
  assign bus.alu_input_1          = a1_d;
  assign bus.alu_input_2          = a2_d;
  assign bus.acc_write_port       = accw_q;
  assign bus.acc_write_bit        = (state_q == S_WB);
  assign bus.instr_req            = (state_q == S_FETCH) || (state_q == S_FETCH_IMM);
  assign bus.instr_addr           = pc_q;
  assign out0                     = out0_q;
  assign out1                     = out1_q;
  assign out2                     = out2_q;
  assign halted                   = (state_q == S_HALT);

endmodule

// File: tb/tb_cpu_ctrl_sequencer.sv
// Directed bench for cpu_ctrl_sequencer with a program memory, ALU and accumulator around it.
module tb_cpu_ctrl_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] in0, in1, in2;
  logic [7:0] out0, out1, out2;
  logic       halted;

  logic [7:0]  mem [256];
  int unsigned wait_cfg;
  int unsigned wcnt;
  logic        stray_valid;
  logic [7:0]  acc;

  int n_checks;
  int n_fail;

  cpu_ctrl_sequencer_if #(.PC_WIDTH(8), .DATA_WIDTH(8)) bus ();

  cpu_ctrl_sequencer #(.PC_WIDTH(8), .DATA_WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .bus   (bus),
    .in0   (in0),
    .in1   (in1),
    .in2   (in2),
    .out0  (out0),
    .out1  (out1),
    .out2  (out2),
    .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program memory with a programmable number of wait cycles per request.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                 wcnt <= 0;
    else if (bus.instr_req && !bus.instr_valid) wcnt <= wcnt + 1;
    else                                        wcnt <= 0;
  end
  assign bus.instr_valid = (bus.instr_req && (wcnt >= wait_cfg)) || stray_valid;
  assign bus.instr_data  = mem[bus.instr_addr];

  function automatic logic [7:0] alu_f(input logic [2:0] s, input logic [7:0] a, input logic [7:0] b);
    case (s)
      3'b000:  return a + b;
      3'b001:  return a * b;
      3'b010:  return a & b;
      3'b011:  return a | b;
      3'b100:  return ~a;
      3'b111:  return a;
      default: return 8'h00;
    endcase
  endfunction
  assign bus.alu_result = alu_f(bus.alu_component_select, bus.alu_input_1, bus.alu_input_2);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 acc <= 8'h00;
    else if (bus.acc_write_bit) acc <= bus.acc_write_port;
  end
  assign bus.acc_read_port = acc;

  typedef struct packed {
    logic [63:0] prog;
    logic [7:0]  i0, i1, i2;
    logic [3:0]  wt;
    logic [7:0]  e0, e1, e2, eacc, epc;
  } vec_t;

  vec_t vecs [8];

  function automatic vec_t mk(input logic [63:0] p, input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] c, input logic [3:0] w, input logic [7:0] e0,
                              input logic [7:0] e1, input logic [7:0] e2, input logic [7:0] ea,
                              input logic [7:0] ep);
    vec_t v;
    v.prog = p; v.i0 = a; v.i1 = b; v.i2 = c; v.wt = w;
    v.e0 = e0; v.e1 = e1; v.e2 = e2; v.eacc = ea; v.epc = ep;
    return v;
  endfunction

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic load_prog(input logic [63:0] p);
    for (int i = 0; i < 256; i++) mem[i] = 8'hF0;
    for (int k = 0; k < 8; k++) mem[k] = p[8*k +: 8];
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    start = 1'b0;
    stray_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_halt(input int unsigned budget, output bit ok);
    ok = 1'b0;
    for (int unsigned i = 0; i < budget; i++) begin
      @(negedge clk);
      if (halted) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    bit ok;
    load_prog(v.prog);
    in0 = v.i0; in1 = v.i1; in2 = v.i2;
    wait_cfg = v.wt;
    apply_reset();
    pulse_start();
    wait_halt(2000, ok);
    check($sformatf("v%0d.done", idx), {15'd0, ok}, 16'd1);
    check($sformatf("v%0d.out0", idx), out0, v.e0);
    check($sformatf("v%0d.out1", idx), out1, v.e1);
    check($sformatf("v%0d.out2", idx), out2, v.e2);
    check($sformatf("v%0d.acc", idx), acc, v.eacc);
    check($sformatf("v%0d.pc", idx), bus.instr_addr, v.epc);
  endtask

  initial begin
    bit ok;
    logic [15:0] req_m, wb_m;
    logic [7:0]  exp_port [3];
    int          k;

    n_checks = 0;
    n_fail = 0;
    wait_cfg = 0;
    stray_valid = 1'b0;
    start = 1'b0;
    in0 = '0; in1 = '0; in2 = '0;
    for (int i = 0; i < 256; i++) mem[i] = 8'hF0;

    // {program bytes 7..0, in0, in1, in2, wait, out0, out1, out2, acc, final pc}
    vecs[0] = mk(64'hF0F0_F0F0_C008_05B8, 8'h00, 8'h03, 8'h00, 4'd0, 8'h08, 8'h00, 8'h00, 8'h08, 8'h05);
    vecs[1] = mk(64'hF0F0_C880_0338_02B8, 8'h55, 8'h00, 8'h00, 4'd0, 8'h00, 8'hF9, 8'h00, 8'hF9, 8'h07);
    vecs[2] = mk(64'hF0C0_0F78_60D0_48A0, 8'h3C, 8'hA5, 8'h00, 4'd0, 8'h3F, 8'h00, 8'h24, 8'h3F, 8'h08);
    vecs[3] = mk(64'hF7D8_C828_D080_1DB0, 8'h00, 8'h10, 8'hF0, 4'd0, 8'h00, 8'h00, 8'h70, 8'h00, 8'h08);
    vecs[4] = mk(64'hF0F0_F0F0_C008_05B8, 8'h00, 8'h03, 8'h00, 4'd3, 8'h08, 8'h00, 8'h00, 8'h08, 8'h05);
    vecs[5] = mk(64'hF0C0_0F78_60D0_48A0, 8'h3C, 8'hA5, 8'h00, 4'd1, 8'h3F, 8'h00, 8'h24, 8'h3F, 8'h08);
`ifdef CTRL_BRANCH_EN
    vecs[6] = mk(64'hF0F0_F0F0_F010_E0A0, 8'h00, 8'h00, 8'h00, 4'd0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h11);
    vecs[7] = mk(64'hF0F0_F0F0_F010_E0A0, 8'h01, 8'h00, 8'h00, 4'd0, 8'h00, 8'h00, 8'h00, 8'h01, 8'h04);
`else
    vecs[6] = mk(64'hF0F0_F0F0_F010_E0A0, 8'h00, 8'h00, 8'h00, 4'd0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02);
    vecs[7] = mk(64'hF0F0_F0F0_F010_E0A0, 8'h01, 8'h00, 8'h00, 4'd0, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02);
`endif

    rst_n = 1'b0;
    #12;
    check("rst.req", {15'd0, bus.instr_req}, 16'd0);
    check("rst.wb", {15'd0, bus.acc_write_bit}, 16'd0);
    check("rst.halted", {15'd0, halted}, 16'd0);
    check("rst.addr", bus.instr_addr, 16'h0);

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // Cycle trace: LOAD imm 2, MUL imm 3, NOT, STORE out1, HALT; a stray start mid-run.
    load_prog(vecs[1].prog);
    in0 = 8'h55; in1 = 8'h00; in2 = 8'h00;
    wait_cfg = 0;
    apply_reset();
    pulse_start();
    req_m = 16'h2933;
    wb_m  = 16'h0488;
    exp_port[0] = 8'h02; exp_port[1] = 8'h06; exp_port[2] = 8'hF9;
    k = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      check($sformatf("tr%0d.req", c), {15'd0, bus.instr_req}, {15'd0, req_m[c]});
      check($sformatf("tr%0d.wb", c), {15'd0, bus.acc_write_bit}, {15'd0, wb_m[c]});
      check($sformatf("tr%0d.halted", c), {15'd0, halted}, {15'd0, c == 15});
      if (wb_m[c] && k < 3) begin
        check($sformatf("tr%0d.port", c), bus.acc_write_port, exp_port[k]);
        k++;
      end
      if (c == 6) begin
        check("tr6.sel", bus.alu_component_select, 16'h1);
        check("tr6.a1", bus.alu_input_1, 16'h02);
        check("tr6.a2", bus.alu_input_2, 16'h03);
      end
      if (c == 8) check("tr8.sel_hold", bus.alu_component_select, 16'h1);
      if (c == 9) begin
        check("tr9.sel", bus.alu_component_select, 16'h4);
        check("tr9.a1", bus.alu_input_1, 16'h06);
      end
      if (c == 4) start = 1'b1;
      if (c == 5) start = 1'b0;
      if (c == 15) start = 1'b1;
    end
    @(negedge clk);
    start = 1'b0;
    check("restart.req", {15'd0, bus.instr_req}, 16'd1);
    check("restart.addr", bus.instr_addr, 16'h0);
    check("restart.halted", {15'd0, halted}, 16'd0);
    check("restart.out1", out1, 16'hF9);

    // Wait states: request held and address stable until valid.
    load_prog(vecs[0].prog);
    in0 = 8'h00; in1 = 8'h03; in2 = 8'h00;
    wait_cfg = 3;
    apply_reset();
    pulse_start();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("ws%0d.req", c), {15'd0, bus.instr_req}, 16'd1);
      check($sformatf("ws%0d.addr", c), bus.instr_addr, (c == 4) ? 16'h1 : 16'h0);
    end

    // Reset during the WB of ADD, then a stray valid in IDLE.
    wait_cfg = 0;
    apply_reset();
    pulse_start();
    repeat (7) @(negedge clk);
    check("wb.pulse", {15'd0, bus.acc_write_bit}, 16'd1);
    check("wb.port", bus.acc_write_port, 16'h08);
    rst_n = 1'b0;
    #1;
    check("arst.wb", {15'd0, bus.acc_write_bit}, 16'd0);
    check("arst.port", bus.acc_write_port, 16'h0);
    check("arst.sel", bus.alu_component_select, 16'h0);
    check("arst.a1", bus.alu_input_1, 16'h0);
    check("arst.req", {15'd0, bus.instr_req}, 16'd0);
    check("arst.outs", {out0, out1 | out2}, 16'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    stray_valid = 1'b1;
    @(negedge clk);
    stray_valid = 1'b0;
    @(negedge clk);
    check("stray.req", {15'd0, bus.instr_req}, 16'd0);
    check("stray.addr", bus.instr_addr, 16'h0);
    pulse_start();
    wait_halt(200, ok);
    check("stray.done", {15'd0, ok}, 16'd1);
    check("stray.out0", out0, 16'h08);
    check("stray.pc", bus.instr_addr, 16'h05);

    // pc wrap: LOAD imm at 0xFF, immediate byte taken from 0x00.
    for (int i = 0; i < 256; i++) mem[i] = 8'hD8;
    mem[255] = 8'hB8;
    wait_cfg = 0;
    apply_reset();
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 1200; i++) begin
      @(negedge clk);
      if (bus.instr_req && bus.instr_addr == 8'hFF) begin
        ok = 1'b1;
        break;
      end
    end
    check("wrap.reach", {15'd0, ok}, 16'd1);
    @(negedge clk);
    check("wrap.imm_req", {15'd0, bus.instr_req}, 16'd1);
    check("wrap.imm_addr", bus.instr_addr, 16'h00);
    @(negedge clk);
    @(negedge clk);
    check("wrap.wb", {15'd0, bus.acc_write_bit}, 16'd1);
    check("wrap.port", bus.acc_write_port, 16'hD8);
    @(negedge clk);
    check("wrap.next_req", {15'd0, bus.instr_req}, 16'd1);
    check("wrap.next_addr", bus.instr_addr, 16'h01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
